// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default geometry, used by both the E-stage controller and mdu_unit.
package mdu_unit_pkg;

   localparam int MDU_WIDTH_DEF = 32;
   localparam int MDU_MULT_DEF  = 5;
   localparam int MDU_DIV_DEF   = 10;
   localparam int MDU_OP_W      = 3;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   function automatic int mdu_max(input int x, input int y);
      if (x > y) begin
         return x;
      end else begin
         return y;
      end
   endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the E stage (master) and the MDU (slave).
interface mdu_unit_if
   import mdu_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH_DEF
);
   logic                start;
   logic [MDU_OP_W-1:0] op;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                busy;
   logic                stall_req;
   logic                done;
   logic [WIDTH-1:0]    hi;
   logic [WIDTH-1:0]    lo;

   modport master (
      output start, op, a, b,
      input  busy, stall_req, done, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, stall_req, done, hi, lo
   );
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO. The result is computed at issue
// into shadow registers and committed after a fixed number of busy cycles.
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int WIDTH       = MDU_WIDTH_DEF,
   parameter int MULT_CYCLES = MDU_MULT_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_DEF
) (
   input  logic      clk,
   input  logic      reset,
   mdu_unit_if.slave bus
);

   localparam int CNT_W = $clog2(mdu_max(MULT_CYCLES, DIV_CYCLES) + 1);

   mdu_state_e          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                busy_r;
   logic                done_r;
   logic [WIDTH-1:0]    hi_r;
   logic [WIDTH-1:0]    lo_r;
   logic [WIDTH-1:0]    pend_hi_r;
   logic [WIDTH-1:0]    pend_lo_r;

   logic                is_signed_s;
   logic signed [2*WIDTH-1:0] ma_s;
   logic signed [2*WIDTH-1:0] mb_s;
   logic signed [2*WIDTH-1:0] prod_s;
   logic signed [WIDTH:0]     da_s;
   logic signed [WIDTH:0]     db_s;
   logic signed [WIDTH:0]     quot_s;
   logic signed [WIDTH:0]     rem_s;
   logic [WIDTH-1:0]    res_hi_s;
   logic [WIDTH-1:0]    res_lo_s;
   logic                unused_s;

   // Issue-time arithmetic; one extra sign/zero bit lets a single signed
   // divider serve both flavours and turns MIN_INT / -1 into MIN_INT, rem 0.
   always_comb begin
      is_signed_s = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
      ma_s   = {{WIDTH{is_signed_s & bus.a[WIDTH-1]}}, bus.a};
      mb_s   = {{WIDTH{is_signed_s & bus.b[WIDTH-1]}}, bus.b};
      prod_s = ma_s * mb_s;
      da_s   = {is_signed_s & bus.a[WIDTH-1], bus.a};
      db_s   = {is_signed_s & bus.b[WIDTH-1], bus.b};
      quot_s = da_s / db_s;
      rem_s  = da_s % db_s;
      res_hi_s = hi_r;
      res_lo_s = lo_r;
      case (bus.op)
         MDU_MULT, MDU_MULTU: begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
         end
         MDU_DIV, MDU_DIVU: begin
            if (bus.b == {WIDTH{1'b0}}) begin
               res_hi_s = hi_r;
               res_lo_s = lo_r;
            end else begin
               res_hi_s = rem_s[WIDTH-1:0];
               res_lo_s = quot_s[WIDTH-1:0];
            end
         end
         default: begin
            res_hi_s = hi_r;
            res_lo_s = lo_r;
         end
      endcase
   end

   assign unused_s = ^{quot_s[WIDTH], rem_s[WIDTH]};

   // Control FSM plus HI/LO, shadow and countdown state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
         pend_hi_r <= {WIDTH{1'b0}};
         pend_lo_r <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     MDU_MULT, MDU_MULTU: begin
                        pend_hi_r <= res_hi_s;
                        pend_lo_r <= res_lo_s;
                        cnt_r     <= CNT_W'(MULT_CYCLES);
                        busy_r    <= 1'b1;
                        state_r   <= ST_BUSY;
                     end
                     MDU_DIV, MDU_DIVU: begin
                        pend_hi_r <= res_hi_s;
                        pend_lo_r <= res_lo_s;
                        cnt_r     <= CNT_W'(DIV_CYCLES);
                        busy_r    <= 1'b1;
                        state_r   <= ST_BUSY;
                     end
                     MDU_MTHI: hi_r <= bus.a;
                     MDU_MTLO: lo_r <= bus.a;
                     default:  state_r <= ST_IDLE;
                  endcase
               end
            end
            ST_BUSY: begin
               // Commit on the edge that retires the last busy cycle.
               if (cnt_r == CNT_W'(1)) begin
                  hi_r    <= pend_hi_r;
                  lo_r    <= pend_lo_r;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stall_req = busy_r | (bus.start & ~bus.op[2]);
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.hi        = hi_r;
   assign bus.lo        = lo_r;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomised plus directed bench for mdu_unit against a plain-arithmetic model
// of HI/LO and the issue-to-commit timing.
module tb_mdu_unit;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_unit_if #(.WIDTH(32)) bus ();

   mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [31:0] av, bv,
                                 input logic [31:0] ch, cl,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint      p;
      logic [63:0] u;
      int          sa, sb;
      eh = ch;
      el = cl;
      sa = av;
      sb = bv;
      case (op)
         3'd0: begin p = longint'(sa) * longint'(sb); eh = p[63:32]; el = p[31:0]; end
         3'd1: begin u = {32'd0, av} * {32'd0, bv}; eh = u[63:32]; el = u[31:0]; end
         3'd2: begin
            if (bv == 32'd0) begin
               eh = ch; el = cl;
            end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
               eh = 32'd0; el = 32'h8000_0000;
            end else begin
               eh = sa % sb; el = sa / sb;
            end
         end
         3'd3: begin
            if (bv != 32'd0) begin eh = av % bv; el = av / bv; end
         end
         3'd4: eh = av;
         3'd5: el = av;
         default: begin eh = ch; el = cl; end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      bus.start = 1'b0;
      step();
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_done", bus.done, 1'b0);
      chk("idle_stall", bus.stall_req, 1'b0);
      chk("idle_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
   endtask

   // Issue op now; for mult/div returns in the done cycle. intr_op>=0 fires a
   // stray start during busy cycle 2, which must be ignored.
   task automatic do_op(input logic [2:0] op, input logic [31:0] av, bv, input int intr_op);
      logic [31:0] eh, el;
      int          n;
      model(op, av, bv, m_hi, m_lo, eh, el);
      bus.start = 1'b1; bus.op = op; bus.a = av; bus.b = bv;
      #1;
      chk("stall_issue", bus.stall_req, (op <= 3'd3));
      step();
      bus.start = 1'b0; bus.op = 3'($urandom_range(7)); bus.a = pick(); bus.b = pick();
      if (op <= 3'd3) begin
         n = (op <= 3'd1) ? 5 : 10;
         for (int k = 1; k <= n; k++) begin
            chk("busy", bus.busy, 1'b1);
            chk("stall_busy", bus.stall_req, 1'b1);
            chk("done_early", bus.done, 1'b0);
            chk("hilo_hold", {bus.hi, bus.lo}, {m_hi, m_lo});
            if (intr_op >= 0 && k == 2) begin
               bus.start = 1'b1; bus.op = 3'(intr_op); bus.a = 32'h0000_DEAD; bus.b = 32'd1;
            end
            step();
            bus.start = 1'b0;
         end
         m_hi = eh; m_lo = el;
         chk("busy_end", bus.busy, 1'b0);
         chk("done", bus.done, 1'b1);
         chk("result", {bus.hi, bus.lo}, {m_hi, m_lo});
      end else begin
         m_hi = eh; m_lo = el;
         chk("mt_busy", bus.busy, 1'b0);
         chk("mt_done", bus.done, 1'b0);
         chk("mt_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      end
   endtask

   initial begin
      logic [2:0] rop;
      total = 0; bad = 0; m_hi = 32'd0; m_lo = 32'd0;
      reset = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
      step(); step();
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      reset = 1'b1;
      idle_step();

      do_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1);
      chk("plan_mult", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      idle_step();
      do_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1);
      chk("plan_multu", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
      idle_step();
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
      chk("plan_div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd3, 32'd7, 32'd0, -1);
      chk("plan_div0", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      idle_step();
      do_op(3'd4, 32'h1234_5678, 32'd0, -1);
      chk("plan_mthi", bus.hi, 32'h1234_5678);
      do_op(3'd2, 32'd100, 32'd7, 5);
      chk("plan_intr", {bus.hi, bus.lo}, {32'd2, 32'd14});
      idle_step();
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      chk("plan_ovf", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
      idle_step();

      // Asynchronous reset in busy cycle 3 of a MULT.
      bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
      step();
      bus.start = 1'b0;
      step(); step();
      chk("pre_rst_busy", bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_done", bus.done, 1'b0);
      m_hi = 32'd0; m_lo = 32'd0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 7; i++) idle_step();
      do_op(3'd5, 32'd5, 32'd0, -1);
      chk("plan_mtlo", bus.lo, 32'd5);

      // Back-to-back: MULT in the done cycle of a DIV.
      do_op(3'd2, 32'd1000, 32'hFFFF_FFFD, -1);
      do_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
      idle_step();

      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(7));
         do_op(rop, pick(), pick(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
         if ($urandom_range(0, 1) == 1) idle_step();
      end
      idle_step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit with architectural HI/LO registers, placed in the E stage beside the ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run over a configurable number of busy cycles. Its stall request lets the stall controller hold any HI/LO-dependent instruction in D until the result is committed.

## Interface
- WIDTH, 32: operand and HI/LO width
- MULT_CYCLES, 5: busy cycles for MULT/MULTU, ≥1
- DIV_CYCLES, 10: busy cycles for DIV/DIVU, ≥1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  issue strobe from E stage, qualified by op
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op
- a  input  WIDTH  rs value, forwarded
- b  input  WIDTH  rt value, forwarded
- busy  output  1  multi-cycle operation in flight
- stall_req  output  1  combinational: busy | (start & op∈{0..3})
- done  output  1  one-cycle pulse in the cycle HI/LO commit becomes visible
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

## Operation
- start with op 0–3 while busy=0 latches the operation:
  - Results are computed from a/b at issue and held in shadow registers pend_hi/pend_lo.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises.
- MULT/MULTU: {hi,lo} = full 2·WIDTH product, signed or unsigned.
- DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero: pend values equal the current hi/lo, so HI/LO are unchanged. done still pulses.
- Signed overflow, MIN_INT / −1: lo = MIN_INT, hi = 0.
- MTHI/MTLO with busy=0: write a to hi or lo at the next edge. No busy, no done.
- Any start while busy=1 is ignored. The stall controller guarantees this cannot happen; the bench checks that nothing changes if it does.
- Op 6–7: no effect.
- stall_req is consumed by the stall controller: a D-stage MFHI/MFLO/MTHI/MTLO/MULT/DIV stalls while stall_req=1.
- States:
  - IDLE → BUSY on a valid mult/div start.
  - BUSY → IDLE when count reaches 1 at an edge. At that same edge, hi/lo take pend values and done is set for the following cycle.

## Timing
- Reset (async, reset=0): hi=0, lo=0, busy=0, done=0, counter=0, pend=0. Takes effect immediately regardless of clk.
- Reset mid-operation: the operation is discarded; HI/LO read 0 after release.
- Start sampled at edge T:
  - busy=1 during cycles T+1 … T+N (N = configured cycles).
  - hi/lo show the new result from cycle T+N+1.
  - done=1 during cycle T+N+1 only.
  - busy=0 in cycle T+N+1.
- Back-to-back issue: a new start is accepted in cycle T+N+1, the same cycle done=1.
- MTHI/MTLO sampled at edge T: value visible at T+1.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- No arithmetic wraps into the counter.

## Structure
- Add MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI and MDU_MTLO op codes to Constants.v alongside the existing ALU/REGWr defines. The controller and mdu_unit share them.
- Single flat module.
- Arithmetic uses inferred * and / / % on sign-extended or zero-extended operands; no separate divider sub-module is needed.
- stall_req is the only combinational output.

## Test plan
- Reset, then MULT with a=0xFFFFFFFE (−2), b=3 → busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
- MULTU with a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV with a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 → hi/lo unchanged, done pulses.
- MTHI a=0x12345678, then immediately issue DIV → hi=0x12345678 one cycle after MTHI. A second start during busy (MTLO a=0xDEAD) is ignored; lo is unchanged and the DIV result is committed as computed.
- Drop reset to 0 at busy cycle 3 of a MULT → hi=lo=0 and busy=0 immediately, no done. After release, MTLO a=5 → lo=5 next cycle.
- Back-to-back: MULT issued in the done cycle of a prior DIV → both results committed in order, and stall_req stays high continuously.
